// File: rtl/hex_display_pkg.sv
// Shared types and constants for the multiplexed hex display scanner:
// active-low segment vector (seg[0]=a .. seg[6]=g) and the hex glyph table.
package hex_display_pkg;

    typedef logic [0:6] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    localparam seg_t SEG_TABLE [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module hex_to_seg
    import hex_display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output seg_t       o_seg
);

    assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex display driver: one digit per slot, frame-synchronous
// updates, leading-zero blanking and PWM brightness on the digit selects.
module hex_display_scanner
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS    = 6,
    parameter int SCAN_DIV      = 50000,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [3:0]              brightness,
    input  logic                    load,
    output seg_t                    seg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    update_pending,
    output logic                    frame_start
);

    localparam int TW    = $clog2(SCAN_DIV);
    localparam int DW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SLICE = SCAN_DIV / 16;

    logic [TW-1:0]           r_tick;
    logic [DW-1:0]           r_digit;

    logic [4*NUM_DIGITS-1:0] r_stg_val;
    logic [NUM_DIGITS-1:0]   r_stg_dp;
    logic [NUM_DIGITS-1:0]   r_stg_en;
    logic [3:0]              r_stg_bri;
    logic                    r_pending;

    logic [4*NUM_DIGITS-1:0] r_dsp_val;
    logic [NUM_DIGITS-1:0]   r_dsp_dp;
    logic [NUM_DIGITS-1:0]   r_dsp_en;
    logic [3:0]              r_dsp_bri;

    seg_t                    r_seg;
    logic                    r_dp_n;
    logic [NUM_DIGITS-1:0]   r_an_n;
    logic                    r_frame_start;

    logic                    w_frame;
    logic                    w_apply;
    logic [4*NUM_DIGITS-1:0] w_val;
    logic [NUM_DIGITS-1:0]   w_dp;
    logic [NUM_DIGITS-1:0]   w_en;
    logic [3:0]              w_bri;
    logic [NUM_DIGITS-1:0]   w_upper_zero;
    logic [DW+1:0]           w_nib_base;
    logic [3:0]              w_nibble;
    seg_t                    w_seg_dec;
    logic                    w_blank;
    logic [TW:0]             w_on_full;
    logic [TW:0]             w_thr;
    logic                    w_lit;
    logic [NUM_DIGITS-1:0]   w_an_next;

    assign w_frame = (r_tick == '0) && (r_digit == '0);
    assign w_apply = w_frame && r_pending;

    // The frame's first slot must already show the newly applied data, so the
    // output path looks through the staging register on the swap cycle.
    assign w_val = w_apply ? r_stg_val : r_dsp_val;
    assign w_dp  = w_apply ? r_stg_dp  : r_dsp_dp;
    assign w_en  = w_apply ? r_stg_en  : r_dsp_en;
    assign w_bri = w_apply ? r_stg_bri : r_dsp_bri;

    always_comb begin
        logic w_run;
        w_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_run           = w_run & (w_val[4*k +: 4] == 4'h0);
            w_upper_zero[k] = w_run;
        end
    end

    assign w_nib_base = {r_digit, 2'b00};
    assign w_nibble   = w_val[w_nib_base +: 4];

    hex_to_seg u_hex_to_seg (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_dec)
    );

    assign w_blank = !w_en[r_digit] ||
                     ((BLANK_LEADING != 0) && (r_digit != '0) && w_upper_zero[r_digit]);

    // Last tick of every slot stays dark so segment changes never ghost.
    assign w_on_full = (TW+1)'({1'b0, w_bri} + 5'd1) * (TW+1)'(SLICE);
    assign w_thr     = (w_on_full > (TW+1)'(SCAN_DIV - 1)) ? (TW+1)'(SCAN_DIV - 1) : w_on_full;
    assign w_lit     = ({1'b0, r_tick} < w_thr) && !w_blank;

    always_comb begin
        w_an_next          = '1;
        w_an_next[r_digit] = !w_lit;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick  <= '0;
            r_digit <= '0;
        end else if (r_tick == TW'(SCAN_DIV - 1)) begin
            r_tick  <= '0;
            r_digit <= (r_digit == DW'(NUM_DIGITS - 1)) ? '0 : r_digit + DW'(1);
        end else begin
            r_tick  <= r_tick + TW'(1);
        end
    end

    // load is a single-cycle strobe with no back-pressure: every asserted cycle
    // overwrites the stage; the stage moves to the display only at frame start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stg_val <= '0;
            r_stg_dp  <= '0;
            r_stg_en  <= '1;
            r_stg_bri <= 4'hF;
            r_pending <= 1'b0;
            r_dsp_val <= '0;
            r_dsp_dp  <= '0;
            r_dsp_en  <= '1;
            r_dsp_bri <= 4'hF;
        end else begin
            if (w_apply) begin
                r_dsp_val <= r_stg_val;
                r_dsp_dp  <= r_stg_dp;
                r_dsp_en  <= r_stg_en;
                r_dsp_bri <= r_stg_bri;
            end
            if (load) begin
                r_stg_val <= value;
                r_stg_dp  <= dp_in;
                r_stg_en  <= digit_en;
                r_stg_bri <= brightness;
                r_pending <= 1'b1;
            end else if (w_frame) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seg         <= SEG_BLANK;
            r_dp_n        <= 1'b1;
            r_an_n        <= '1;
            r_frame_start <= 1'b0;
        end else begin
            r_seg         <= w_blank ? SEG_BLANK : w_seg_dec;
            r_dp_n        <= w_blank ? 1'b1 : !w_dp[r_digit];
            r_an_n        <= w_an_next;
            r_frame_start <= w_frame;
        end
    end

    assign seg            = r_seg;
    assign dp_n           = r_dp_n;
    assign an_n           = r_an_n;
    assign frame_start    = r_frame_start;
    assign update_pending = r_pending;

endmodule

// File: doc/hex_display_scanner.md
HEX_DISPLAY_SCANNER -- requirements
Module: hex_display_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 6: number of multiplexed hex digits (legal 1..8).
REQ-002 Parameter SCAN_DIV, default 50000: clock cycles per digit slot (legal 16..2^20, multiple of 16).
REQ-003 Parameter BLANK_LEADING, default 1: 1 = leading-zero suppression enabled.
REQ-004 clk  input  1: single clock; all state on rising edge.
REQ-005 reset_n  input  1: asynchronous, active-low reset.
REQ-006 value  input  4*NUM_DIGITS: hex nibbles; nibble k = digit k, digit 0 least significant.
REQ-007 dp_in  input  NUM_DIGITS: decimal-point request per digit, 1 = lit.
REQ-008 digit_en  input  NUM_DIGITS: per-digit enable, 0 = digit forced blank.
REQ-009 brightness  input  4: on-time level, 0 dimmest, 15 full.
REQ-010 load  input  1: single-cycle strobe; captures value/dp_in/digit_en/brightness.
REQ-011 seg  output  [0:6]: segments a..g, active-low, seg[0]=a, seg[6]=g.
REQ-012 dp_n  output  1: decimal point, active-low.
REQ-013 an_n  output  NUM_DIGITS: digit select, active-low, at most one bit low.
REQ-014 update_pending  output  1: captured data not yet applied to display.
REQ-015 frame_start  output  1: one-cycle pulse at start of each frame.

Function
REQ-016 Slot counter tick counts 0..SCAN_DIV-1, then wraps to 0 and digit index advances 0,1,..,NUM_DIGITS-1,0.
REQ-017 Frame start = tick==0 and digit index==0; frame_start is high that cycle, including the first cycle after reset release.
REQ-018 load captures the inputs into a staging register and sets update_pending; a load while pending overwrites the staged data.
REQ-019 At frame start, a pending stage is copied to the display register and update_pending clears; load in that same cycle is staged for the next frame with update_pending remaining 1.
REQ-020 Display contents never change mid-frame (no tearing).
REQ-021 Nibble decode, active-low hex: 0=01 1=4F 2=12 3=06 4=4C 5=24 6=20 7=0F 8=00 9=04 A=08 B=60 C=31 D=42 E=30 F=38.
REQ-022 Blank pattern: seg=7F, dp_n=1, an_n bit=1 for whole slot.
REQ-023 Digit blank if digit_en bit=0, or BLANK_LEADING=1 and it and all higher digits are 0; digit 0 is never leading-zero blanked.
REQ-024 On-time: an_n bit low only while tick < min(((brightness+1)*SCAN_DIV)>>4, SCAN_DIV-1); last cycle of each slot always dark (anti-ghost).
REQ-025 seg/dp_n/an_n/frame_start are registered: one cycle latency from counter state.
REQ-026 seg/dp_n hold the active digit's pattern for the whole slot; only an_n is modulated.

Reset
REQ-027 reset_n low immediately forces seg=7F, dp_n=1, an_n=all ones, frame_start=0, update_pending=0.
REQ-028 Reset clears tick, digit index, staging and display registers (value 0, dp 0, digit_en all ones, brightness 15).
REQ-029 Reset mid-frame discards pending data; scan restarts at digit 0 after release.

Structure
REQ-030 Package hex_display_pkg holds the 16-entry segment table, SEG_BLANK=7'h7F, and segment-vector typedef.
REQ-031 One sub-module hex_to_seg (combinational nibble -> active-low segments) is instantiated once, on the selected digit.

Verification (NUM_DIGITS=4, SCAN_DIV=16)
REQ-032 Reset asserted mid-slot -> same cycle seg=7F, an_n=F, update_pending=0.
REQ-033 load value=16'h12AF, digit_en=F, brightness=15 -> next frame slots 0..3: seg 38,08,12,4F; an_n low 15 cycles/slot.
REQ-034 value=16'h0050, BLANK_LEADING=1 -> digits 3,2 dark; digit1=24, digit0=01; value=0 -> digit0 only, 01.
REQ-035 load at digit 2 slot -> update_pending=1, old data until frame_start, new data from digit 0, pending cleared.
REQ-036 brightness=3 -> an_n low 4 cycles of 16; brightness=0 -> 1 cycle; digit_en=4'b1011 -> digit 2 dark.
REQ-037 load coincident with frame_start -> staged, applied next frame, update_pending stays 1.
